// File: rtl/conv1d_pipe.sv
// -----------------------------------------------------------------------------
// conv1d_pipe
//   Streaming 1-D convolution engine for the SIFT Gaussian/DoG filter path.
//   Each accepted beat carries a full window of TAPS unsigned pixels. The block
//   multiplies every tap by its run-time-loadable coefficient, reduces the
//   products through a pipelined binary adder tree and optionally rounds and
//   normalises the sum by 2^SHIFT, saturating into OUT_W bits.
//
//   Pipeline: S0 multiply, S1..S(AW) adder tree, S(AW+1) output register.
//   Latency AW+2 cycles, throughput one window per cycle. Every stage carries
//   its own valid bit and norm flag; the whole pipe freezes while the output
//   register holds a result that downstream has not taken.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   coef_we    coefficient write strobe
//   coef_addr  tap index to write (indices >= TAPS are ignored)
//   coef_data  coefficient value
//   in_valid   input window valid
//   in_ready   block can accept a window (low only while output is stalled)
//   in_norm    per-beat mode: 1 = round + shift, 0 = raw sum
//   din        window, tap i at [i*DATA_W +: DATA_W]
//   out_valid  result valid
//   out_ready  downstream accepts result
//   dout       result
//   dout_sat   result was clipped to all ones
// -----------------------------------------------------------------------------
module conv1d_pipe #(
  parameter int  DATA_W = 10,
  parameter int  COEF_W = 8,
  parameter int  TAPS   = 8,
  parameter int  SHIFT  = 8,
  parameter int  OUT_W  = 21,
  localparam int AW     = $clog2(TAPS),
  localparam int FULL_W = DATA_W + COEF_W + AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic [COEF_W-1:0]      coef_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_norm,
  input  logic [TAPS*DATA_W-1:0] din,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       dout,
  output logic                   dout_sat
);

  // Rounding constant: half of the normalisation step, at FULL_W+1 bits.
  localparam logic [FULL_W:0] RND = (FULL_W+1)'(1) << (SHIFT-1);

  // Number of live nodes at a given tree level (level 0 = products).
  function automatic int node_cnt(input int lvl);
    return (TAPS + (1 << lvl) - 1) >> lvl;
  endfunction

  logic                stall;
  logic [COEF_W-1:0]   coef_q [TAPS];
  logic [FULL_W-1:0]   tree_d [AW+1][TAPS];
  logic [FULL_W-1:0]   tree_q [AW+1][TAPS];
  logic [AW:0]         v_q;
  logic [AW:0]         n_q;
  logic [FULL_W-1:0]   sum;
  logic [FULL_W:0]     sum_rnd;
  logic [FULL_W:0]     r;
  logic [OUT_W-1:0]    dout_d;
  logic                sat_d;

  // The only backpressure point is the output register: when it holds an
  // untaken result, every stage freezes so no window is lost or duplicated.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // ---------------------------------------------------------------------------
  // Coefficient bank. Independent of the stall so a write is never dropped;
  // windows already past S0 hold products and cannot see the new value.
  // ---------------------------------------------------------------------------
  // NOTE: this small register bank has a reset because results after reset must
  // be deterministic (all-zero); large RAM-style memories normally get none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (coef_we && (32'(coef_addr) < TAPS)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for S0 (products) and the adder-tree levels.
  // Products read coef_q before any same-edge write lands, so a window accepted
  // together with a write uses the old coefficient.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < TAPS; j++) begin : g_mul
    assign tree_d[0][j] = FULL_W'(din[j*DATA_W +: DATA_W]) * FULL_W'(coef_q[j]);
  end

  for (genvar l = 1; l <= AW; l++) begin : g_lvl
    localparam int NPREV = node_cnt(l-1);
    for (genvar j = 0; j < TAPS; j++) begin : g_node
      if (2*j+1 < NPREV) begin : g_add
        assign tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
      end else if (2*j < NPREV) begin : g_pass
        // Unpaired term of an odd-sized level passes straight through.
        assign tree_d[l][j] = tree_q[l-1][2*j];
      end else begin : g_zero
        assign tree_d[l][j] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S0..S(AW) registers with per-stage valid and norm flags. Bubbles advance
  // like data; nothing is collapsed.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      n_q <= '0;
      for (int l = 0; l <= AW; l++)
        for (int j = 0; j < TAPS; j++)
          tree_q[l][j] <= '0;
    end else if (!stall) begin
      v_q <= {v_q[AW-1:0], in_valid};
      n_q <= {n_q[AW-1:0], in_norm};
      for (int l = 0; l <= AW; l++)
        for (int j = 0; j < TAPS; j++)
          tree_q[l][j] <= tree_d[l][j];
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: optional round + shift, then saturate into OUT_W bits.
  // ---------------------------------------------------------------------------
  assign sum = tree_q[AW][0];

  // NOTE: every signal written here gets a value on every path (defaults
  // first) so the block stays purely combinational and infers no latch.
  always_comb begin
    sum_rnd = {1'b0, sum} + RND;
    r       = {1'b0, sum};
    if (n_q[AW]) r = sum_rnd >> SHIFT;
  end

  if (OUT_W <= FULL_W) begin : g_sat
    assign sat_d  = |r[FULL_W:OUT_W];
    assign dout_d = sat_d ? '1 : r[OUT_W-1:0];
  end else begin : g_nosat
    assign sat_d  = 1'b0;
    assign dout_d = OUT_W'(r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      dout_sat  <= 1'b0;
    end else if (!stall) begin
      out_valid <= v_q[AW];
      dout      <= dout_d;
      dout_sat  <= sat_d;
    end
  end

endmodule

// File: doc/conv1d_pipe.md
Name: conv1d_pipe

Overview:
- Parametrised streaming 1-D convolution engine for the SIFT Gaussian/DoG filter path.
- Each accepted input beat carries a full window of TAPS unsigned pixels; the block forms the dot product with a run-time-loadable coefficient bank.
- Optionally rounds and normalises the result by a power-of-two shift, with saturation.
- Replaces fixed-tap, counter-enabled convolvers with per-beat valid tracking and output backpressure.

Parameters:
- DATA_W, 10, unsigned pixel width.
- COEF_W, 8, unsigned coefficient width.
- TAPS, 8, window length; legal range 2..16.
- SHIFT, 8, normalisation right-shift; legal range 1..FULL_W-1.
- OUT_W, 21, output width.
- Derived, not overridable: FULL_W = DATA_W + COEF_W + clog2(TAPS) (21 at defaults).
- Derived, not overridable: AW = clog2(TAPS).

Ports:
- clk  in  1  Single clock. All logic is rising-edge.
- rst  in  1  Asynchronous, active-high reset.
- coef_we  in  1  Coefficient write strobe.
- coef_addr  in  AW  Tap index to write.
- coef_data  in  COEF_W  Coefficient value.
- in_valid  in  1  Input window valid.
- in_ready  out  1  Block can accept a window.
- in_norm  in  1  Per-beat mode: 1 = round+shift, 0 = raw sum.
- din  in  TAPS*DATA_W  Window. Tap i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  Result valid.
- out_ready  in  1  Downstream accepts result.
- dout  out  OUT_W  Result.
- dout_sat  out  1  Result was clipped.

Behaviour:
- Reset: all coefficients, all pipeline registers, all stage-valid bits, out_valid, dout and dout_sat go to 0. in_ready is 1 once rst deasserts.
- Coefficient bank:
  - TAPS registers; write on coef_we at the clock edge.
  - coef_addr >= TAPS is ignored.
  - A write in cycle n affects windows accepted in cycle n+1 onward. A window accepted in the same cycle as a write uses the old value.
- Pipeline stages, each with its own valid bit and a copy of the norm flag:
  - S0 multiply: TAPS products of DATA_W+COEF_W bits.
  - S1..S(AW) adder tree: binary pairwise sums. Odd counts pass the unpaired term through.
  - S(AW+1) output: normalise/saturate into dout.
  - Latency: AW+2 cycles from acceptance to out_valid (5 at TAPS=8). Throughput 1 window/cycle.
- Handshake:
  - Accept when in_valid && in_ready.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - On stall, every stage holds its contents.
  - dout, dout_sat and out_valid stay stable while out_valid && !out_ready.
  - Bubbles (invalid stages) advance; no collapsing of bubbles is required.
- Arithmetic (all unsigned, sum held at FULL_W, no internal overflow):
  - norm=0: r = sum.
  - norm=1: r = (sum + 2^(SHIFT-1)) >> SHIFT. The addition is done at FULL_W+1 bits.
  - If r > 2^OUT_W - 1: dout = all ones, dout_sat = 1. Otherwise dout = r, dout_sat = 0.
- Reset mid-operation flushes all in-flight windows. No out_valid is produced for them.
- Simultaneous coefficient write and stall: the write is taken; stalled windows already past S0 are unaffected.

Test Plan:
- Load k = 1..8, window all 1023, norm=0 -> dout = 36828 exactly 5 cycles after acceptance, dout_sat = 0.
- Load k = {1,7,21,99,99,21,7,1} (sum 256), window all 500, norm=1, SHIFT=8 -> dout = 500.
- Rounding: k0 = 1, others 0, window tap0 = 384, norm=1 -> (384+128)>>8 = dout 2; tap0 = 383 -> dout 1.
- Saturation build with OUT_W=12: k all 255, window all 1023, norm=0 -> dout = 4095, dout_sat = 1.
- Backpressure:
  - Stream 10 windows back-to-back with out_ready low for cycles 6-9.
  - Required: in_ready low exactly while out_valid && !out_ready.
  - Required: all 10 results emitted in order, no loss or duplication, dout stable during the stall.
- Coefficient timing and reset:
  - Write k0 = 5 in the same cycle a window is accepted -> that window uses the old k0 and the next uses 5.
  - Assert rst with 3 windows in flight -> no out_valid afterwards; coefficients read back as 0 (all-zero results).
